event_encoder8to3: RTL
======================

# event_encoder8to3

Sequential 8:3 encoder, the inverse of the team's 3:8 one-hot decoder. It accepts an 8-bit request vector over a valid/ready handshake and emits the 3-bit index of every set bit, one index per accepted output beat, in fixed priority order. It sits between event or interrupt sources that raise bit-vectors and downstream logic that consumes binary indices, for example a decoder-driven select.

## Interface
- `LSB_FIRST`, default 1: 1 emits the lowest set index first; 0 emits the highest set index first.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: a request vector is offered on `data_in`.
- `in_ready` out 1: the block can accept a vector this cycle.
- `data_in` in 8: request vector; bit i set means "emit index i".
- `out_valid` out 1: `data_out` holds a valid index.
- `out_ready` in 1: the consumer accepts `data_out` this cycle.
- `data_out` out 3: binary index of the current highest-priority pending bit.
- `out_last` out 1: the current beat is the final index of its vector.
- `zero_err` out 1: one-cycle pulse; an all-zero vector was accepted and dropped.

## Operation
- Internal state: FSM {IDLE, EMIT}; `pending[7:0]` register.
- **IDLE**
  - `in_ready` = 1, `out_valid` = 0.
  - Accept (`in_valid && in_ready`) with `data_in != 0`: `pending <= data_in`, go to EMIT.
  - Accept with `data_in == 0`: stay in IDLE; `zero_err` = 1 on the next cycle only.
- **EMIT**
  - `out_valid` = 1.
  - `data_out` = priority-encode(`pending`), direction set by `LSB_FIRST`.
  - `out_last` = 1 iff `pending` has exactly one bit set.
- **EMIT, `out_ready` = 1**
  - Clear the emitted bit in `pending`.
  - If `out_last`, leave EMIT; otherwise stay in EMIT with the next index.
- **Back-to-back:** `in_ready` = IDLE OR (`out_valid && out_ready && out_last`). A vector accepted on the last beat loads `pending` directly.
  - Nonzero vector: stay in EMIT.
  - Zero vector: go to IDLE and pulse `zero_err`.
- **No overlap otherwise:** `in_ready` = 0 in EMIT when the current beat is not the last accepted one; `data_in` is ignored.
- **Stall:** while `out_valid && !out_ready`, `data_out`, `out_last` and `pending` hold stable.
- **Valid rule:** `out_valid` never drops without a handshake, except on reset.

## Timing
- **Reset values (cycle after `rst` high):**
  - state IDLE, `pending` = 8'h00.
  - `out_valid` = 0, `data_out` = 3'd0, `out_last` = 0, `zero_err` = 0, `in_ready` = 1.
- **During `rst`:** `in_valid` and `out_ready` are ignored.
- **Reset mid-EMIT:** discard the remaining indices. No `out_last` beat is produced for the aborted vector.
- **Latency:** vector accepted at edge N; first index valid at cycle N+1.
- **Throughput:** one index per cycle under continuous `out_ready`. A vector with k set bits occupies exactly k output cycles, with zero bubbles between vectors.
- **Registered outputs:** `out_valid`, `data_out`, `out_last` and `zero_err` derive only from registers.
  - `in_ready` has one combinational term, from `out_ready`.
  - No combinational path from `data_in` or `in_valid` to any output.
- **Widths:** `data_out` is exactly 3 bits; index 7 is `3'b111`. There is no overflow case.
- **8'hFF:** eight beats, indices 0..7 in order (`LSB_FIRST` = 1); `out_last` only on index 7.

## Structure
- **Shared package `enc_pkg`:**
  - `VEC_W` = 8, `IDX_W` = 3.
  - State enum {IDLE, EMIT}.
  - Function `onehot_count_is_one`.
- **Sub-module `pri_enc8`:**
  - Purely combinational; 8-bit vector in, 3-bit index out.
  - Parameter `LSB_FIRST`.
  - Instantiated once on `pending`.
- **Top level:** holds the FSM, the `pending` register, the handshake logic and the `zero_err` pulse.

## Test plan
- **Single bit:** after reset, `data_in` = 8'h20 with `in_valid` for 1 cycle, `out_ready` = 1 -> exactly one beat: `data_out` = 3'd5, `out_last` = 1, then IDLE.
- **Multi-bit order:** `data_in` = 8'hA5, `LSB_FIRST` = 1 -> `data_out` sequence 0, 2, 5, 7, with `out_last` only on 7. With `LSB_FIRST` = 0 -> sequence 7, 5, 2, 0.
- **Backpressure:** `data_in` = 8'h0C, with `out_ready` low for 3 cycles after `out_valid` rises -> `data_out` holds 2 with `out_valid` = 1 throughout the stall, then 2, 3 in order.
- **Back-to-back:** vectors 8'h81 then 8'h02 with `in_valid` held and `out_ready` = 1 -> beats 0, 7(last), 1(last) on consecutive cycles. `in_ready` = 1 on the 7-beat.
- **Zero vector:** `data_in` = 8'h00 accepted in IDLE -> `zero_err` = 1 for exactly one cycle, `out_valid` stays 0, `in_ready` stays 1.
- **Reset mid-operation:** 8'hFF accepted, `rst` high after 3 beats -> next cycle `out_valid` = 0, `pending` = 8'h00, and no further beats.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared widths, FSM state type and small helpers for the event 8:3 encoder.
package enc_pkg;

  localparam int VEC_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  // True when exactly one bit of the vector is set.
  function automatic logic onehot_count_is_one(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-bit priority encoder; LSB_FIRST picks which end wins.
module pri_enc8
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx
);

  // Scan from the low-priority end so the winning bit is assigned last.
  if (LSB_FIRST) begin : g_lsb
    always_comb begin
      idx = '0;
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end else begin : g_msb
    always_comb begin
      idx = '0;
      for (int i = 0; i < VEC_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/event_encoder8to3.sv
// Sequential 8:3 encoder: accepts a request vector, then streams the index of
// every set bit in priority order over a valid/ready output.
module event_encoder8to3
  import enc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] data_out,
  output logic             out_last,
  output logic             zero_err
);

  enc_state_t       state_reg;
  logic [VEC_W-1:0] pending;
  logic             zero_err_reg;
  logic [IDX_W-1:0] cur_idx;
  logic [VEC_W-1:0] clear_mask;
  logic             beat_done;

  pri_enc8 #(
    .LSB_FIRST(LSB_FIRST)
  ) u_pri_enc (
    .vec(pending),
    .idx(cur_idx)
  );

  // All output beat fields come straight from state_reg and pending.
  assign out_valid  = (state_reg == EMIT);
  assign data_out   = cur_idx;
  assign out_last   = onehot_count_is_one(pending);
  assign zero_err   = zero_err_reg;
  assign clear_mask = VEC_W'(1) << cur_idx;
  assign beat_done  = out_valid && out_ready;
  assign in_ready   = (state_reg == IDLE) || (beat_done && out_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending      <= '0;
      zero_err_reg <= 1'b0;
    end else begin
      zero_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (data_in != '0) begin
              pending   <= data_in;
              state_reg <= EMIT;
            end else begin
              zero_err_reg <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              // Last beat doubles as an accept slot for the next vector.
              if (in_valid && (data_in != '0)) begin
                pending <= data_in;
              end else begin
                pending      <= '0;
                state_reg    <= IDLE;
                zero_err_reg <= in_valid;
              end
            end else begin
              pending <= pending & ~clear_mask;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          pending   <= '0;
        end
      endcase
    end
  end

endmodule
